// File: rtl/lcd_str_writer.sv
// Writes two 16-character ASCII lines to an HD44780-compatible LCD over the 8-bit bus.
// Runs the power-up/init sequence after reset, then rewrites both lines on each update request.
module lcd_str_writer #(
   parameter int unsigned T_POWERUP = 1500000,
   parameter int unsigned E_PULSE   = 50,
   parameter int unsigned T_CMD     = 5000,
   parameter int unsigned T_CLEAR   = 200000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] str_l1,
   input  logic [127:0] str_l2,
   input  logic         update,
   output logic         busy,
   output logic         init_done,
   output logic         lcd_e,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic [7:0]   lcd_db
);
   localparam int unsigned CW = 24;
   localparam int unsigned IW = 6;
   localparam logic [IW-1:0] INIT_LAST = IW'(5);
   localparam logic [IW-1:0] REF_LAST  = IW'(33);

   typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, REFRESH} state_t;
   typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

   state_t          state_q, state_d;
   phase_t          phase_q, phase_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            pending_q, pending_d;
   logic            init_done_q, init_done_d;
   logic            busy_q, busy_d;
   logic            lcd_e_q, lcd_e_d;
   logic            lcd_rs_q, lcd_rs_d;
   logic [7:0]      lcd_db_q, lcd_db_d;
   logic [127:0]    l1_q, l2_q;
   logic            load_c;
   logic            issue_c;
   logic [CW-1:0]   hold_last_c;
   logic [8:0]      wr_w_c;

   // {rs, db} for write number i of the init sequence or of a refresh
   function automatic logic [8:0] wr_word(input state_t st, input logic [IW-1:0] i,
                                          input logic [127:0] a, input logic [127:0] b);
      logic [8:0] w;
      logic [3:0] col;
      w   = 9'h000;
      col = 4'd0;
      if (st == INIT) begin
         case (i)
            IW'(0), IW'(1), IW'(2): w = 9'h038;
            IW'(3):                 w = 9'h00C;
            IW'(4):                 w = 9'h006;
            default:                w = 9'h001;
         endcase
      end else if (i == IW'(0)) begin
         w = 9'h080;
      end else if (i < IW'(17)) begin
         col = 4'(IW'(16) - i);
         w   = {1'b1, a[{col, 3'b000} +: 8]};
      end else if (i == IW'(17)) begin
         w = 9'h0C0;
      end else begin
         col = 4'(IW'(33) - i);
         w   = {1'b1, b[{col, 3'b000} +: 8]};
      end
      return w;
   endfunction

   assign hold_last_c = (state_q == INIT && idx_q == INIT_LAST) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= PWR_WAIT;
         phase_q     <= SETUP;
         cnt_q       <= '0;
         idx_q       <= '0;
         pending_q   <= 1'b0;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         lcd_e_q     <= 1'b0;
         lcd_rs_q    <= 1'b0;
         lcd_db_q    <= 8'h00;
         l1_q        <= '0;
         l2_q        <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         pending_q   <= pending_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         lcd_e_q     <= lcd_e_d;
         lcd_rs_q    <= lcd_rs_d;
         lcd_db_q    <= lcd_db_d;
         if (load_c) begin
            l1_q <= str_l1;
            l2_q <= str_l2;
         end
      end
   end

   // Output registers are fed from the next state so rs/db/e line up with the write phases
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q + CW'(1);
      idx_d       = idx_q;
      pending_d   = pending_q;
      init_done_d = init_done_q;
      lcd_rs_d    = lcd_rs_q;
      lcd_db_d    = lcd_db_q;
      load_c      = 1'b0;
      issue_c     = 1'b0;
      wr_w_c      = 9'h000;

      if (update && state_q != IDLE) pending_d = 1'b1;

      case (state_q)
         PWR_WAIT: begin
            if (cnt_q == CW'(T_POWERUP - 1)) begin
               state_d = INIT;
               phase_d = SETUP;
               idx_d   = '0;
               cnt_d   = '0;
               issue_c = 1'b1;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (update || pending_q) begin
               state_d   = REFRESH;
               phase_d   = SETUP;
               idx_d     = '0;
               pending_d = 1'b0;
               load_c    = 1'b1;
               issue_c   = 1'b1;
            end
         end
         default: begin
            case (phase_q)
               SETUP: begin
                  phase_d = STROBE;
                  cnt_d   = '0;
               end
               STROBE: begin
                  if (cnt_q == CW'(E_PULSE - 1)) begin
                     phase_d = HOLD;
                     cnt_d   = '0;
                  end
               end
               HOLD: begin
                  if (cnt_q == hold_last_c) begin
                     cnt_d = '0;
                     if (idx_q == ((state_q == INIT) ? INIT_LAST : REF_LAST)) begin
                        if (state_q == INIT) init_done_d = 1'b1;
                        // A request seen during init/refresh chains straight into a new refresh
                        if (update || pending_q) begin
                           state_d   = REFRESH;
                           phase_d   = SETUP;
                           idx_d     = '0;
                           pending_d = 1'b0;
                           load_c    = 1'b1;
                           issue_c   = 1'b1;
                        end else begin
                           state_d = IDLE;
                           phase_d = SETUP;
                        end
                     end else begin
                        idx_d   = idx_q + IW'(1);
                        phase_d = SETUP;
                        issue_c = 1'b1;
                     end
                  end
               end
               default: phase_d = SETUP;
            endcase
         end
      endcase

      if (issue_c) begin
         wr_w_c   = wr_word(state_d, idx_d, l1_q, l2_q);
         lcd_rs_d = wr_w_c[8];
         lcd_db_d = wr_w_c[7:0];
      end

      lcd_e_d = (state_d == INIT || state_d == REFRESH) && phase_d == STROBE;
      busy_d  = state_d != IDLE;
   end

   assign busy      = busy_q;
   assign init_done = init_done_q;
   assign lcd_e     = lcd_e_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_db    = lcd_db_q;
endmodule

// File: tb/tb_lcd_str_writer.sv
// Bench for lcd_str_writer: a negedge monitor captures every E pulse; expected write
// lists and pulse cycles come from a write-list model built from the display rules.
module tb_lcd_str_writer;
   localparam int unsigned TP  = 20;
   localparam int unsigned EP  = 2;
   localparam int unsigned TC  = 4;
   localparam int unsigned TCL = 10;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] str_l1 = '0;
   logic [127:0] str_l2 = '0;
   logic         update = 1'b0;
   logic         busy, init_done, lcd_e, lcd_rs, lcd_rw;
   logic [7:0]   lcd_db;

   always #5 clk = ~clk;

   lcd_str_writer #(.T_POWERUP(TP), .E_PULSE(EP), .T_CMD(TC), .T_CLEAR(TCL)) dut (
      .clk(clk), .rst(rst), .str_l1(str_l1), .str_l2(str_l2), .update(update),
      .busy(busy), .init_done(init_done), .lcd_e(lcd_e), .lcd_rs(lcd_rs),
      .lcd_rw(lcd_rw), .lcd_db(lcd_db)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   typedef struct {
      logic [8:0] w;
      int         c;
      logic       ok;
   } pulse_t;

   pulse_t     mon_q[$];
   logic       e_prev = 1'b0;
   logic [8:0] prev_w = 9'h000;
   int         hi_len = 0;
   int         stab_err = 0;
   int         ep_err = 0;

   always @(negedge clk) begin
      if (rst) begin
         e_prev <= 1'b0;
         hi_len <= 0;
      end else begin
         if (lcd_e && !e_prev)
            mon_q.push_back('{w: {lcd_rs, lcd_db}, c: cyc, ok: ({lcd_rs, lcd_db} == prev_w)});
         if (lcd_e && e_prev && {lcd_rs, lcd_db} != prev_w) stab_err <= stab_err + 1;
         if (lcd_e) hi_len <= hi_len + 1;
         else begin
            if (e_prev && hi_len != int'(EP)) ep_err <= ep_err + 1;
            hi_len <= 0;
         end
         e_prev <= lcd_e;
      end
      prev_w <= {lcd_rs, lcd_db};
   end

   // Reference model: list of {rs,db} writes and the cycle each E pulse should start
   logic [8:0] exp_w[$];
   int         exp_c[$];
   int         mt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_model(input int t0);
      exp_w.delete();
      exp_c.delete();
      mon_q.delete();
      mt = t0;
   endtask

   task automatic add_wr(input logic [8:0] w);
      exp_w.push_back(w);
      exp_c.push_back(mt + 1);
      mt = mt + 1 + int'(EP) + ((w == 9'h001) ? int'(TCL) : int'(TC));
   endtask

   task automatic add_init();
      add_wr(9'h038); add_wr(9'h038); add_wr(9'h038);
      add_wr(9'h00C); add_wr(9'h006); add_wr(9'h001);
   endtask

   task automatic add_refresh(input logic [127:0] a, input logic [127:0] b);
      add_wr(9'h080);
      for (int col = 0; col < 16; col++) add_wr({1'b1, a[8*(15-col) +: 8]});
      add_wr(9'h0C0);
      for (int col = 0; col < 16; col++) add_wr({1'b1, b[8*(15-col) +: 8]});
   endtask

   task automatic compare_pulses(input string tag);
      check({tag, "_count"}, mon_q.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < mon_q.size(); i++) begin
         check($sformatf("%s_word[%0d]", tag, i), 32'(mon_q[i].w), 32'(exp_w[i]));
         check($sformatf("%s_cycle[%0d]", tag, i), mon_q[i].c, exp_c[i]);
         check($sformatf("%s_setup[%0d]", tag, i), 32'(mon_q[i].ok), 32'd1);
      end
   endtask

   task automatic pulse_update();
      update = 1'b1;
      step();
      update = 1'b0;
   endtask

   task automatic wait_init_done(output int c);
      int k = 0;
      while (!init_done && k < 2000) begin step(); k++; end
      check("init_done_timeout", 32'(init_done), 32'd1);
      c = cyc;
   endtask

   task automatic wait_busy_low(output int c);
      int k = 0;
      while (busy && k < 2000) begin step(); k++; end
      check("busy_low_timeout", 32'(busy), 32'd0);
      c = cyc;
   endtask

   function automatic logic [127:0] rand_str();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int c, u, k;
      logic [127:0] s1, s2, s3, s4;

      // reset state
      step(2);
      check("rst_lcd_e", 32'(lcd_e), 32'd0);
      check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
      check("rst_lcd_db", 32'(lcd_db), 32'h00);
      check("rst_lcd_rw", 32'(lcd_rw), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_init_done", 32'(init_done), 32'd0);

      // initialisation
      rst = 1'b0;
      clear_model(int'(TP));
      add_init();
      wait_init_done(c);
      check("init_done_cycle", c, mt);
      check("init_busy_low", 32'(busy), 32'd0);
      compare_pulses("init");

      // directed refresh
      str_l1 = "0000000000001010";
      str_l2 = "................";
      u = cyc;
      clear_model(u + 1);
      add_refresh(str_l1, str_l2);
      pulse_update();
      wait_busy_low(c);
      check("ref_end_cycle", c, mt);
      check("ref_span", c - (u + 1), 238);
      compare_pulses("ref");
      check("ref_init_done_held", 32'(init_done), 32'd1);

      // latching: inputs change mid-refresh
      s1 = rand_str(); s2 = rand_str();
      str_l1 = s1; str_l2 = s2;
      u = cyc;
      clear_model(u + 1);
      add_refresh(s1, s2);
      pulse_update();
      step(9);
      str_l1 = {16{8'h31}};
      wait_busy_low(c);
      check("latch_end_cycle", c, mt);
      step(50);
      compare_pulses("latch");
      check("latch_stays_idle", 32'(busy), 32'd0);

      // pending: three requests during a refresh, last in its final cycle
      s1 = rand_str(); s2 = rand_str(); s3 = rand_str(); s4 = rand_str();
      str_l1 = s1; str_l2 = s2;
      u = cyc;
      clear_model(u + 1);
      add_refresh(s1, s2);
      pulse_update();
      step(4);
      pulse_update();
      while (cyc < u + 100) step();
      pulse_update();
      while (cyc < u + 150) step();
      str_l1 = s3; str_l2 = s4;
      while (cyc < u + 238) step();
      pulse_update();
      add_refresh(s3, s4);
      wait_busy_low(c);
      check("pend_end_cycle", c, mt);
      step(30);
      compare_pulses("pend");
      check("pend_stays_idle", 32'(busy), 32'd0);

      // reset in the middle of an E strobe, with a request pending
      str_l1 = rand_str(); str_l2 = rand_str();
      pulse_update();
      pulse_update();
      k = 0;
      while (!lcd_e && k < 50) begin step(); k++; end
      check("mid_e_seen", 32'(lcd_e), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_lcd_e", 32'(lcd_e), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd1);
      check("mid_rst_init_done", 32'(init_done), 32'd0);
      step(2);
      rst = 1'b0;
      clear_model(int'(TP));
      add_init();
      wait_init_done(c);
      check("reinit_done_cycle", c, mt);
      check("reinit_busy_low", 32'(busy), 32'd0);
      step(40);
      compare_pulses("reinit");
      check("reinit_no_refresh", 32'(busy), 32'd0);

      // request during power-up wait
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      clear_model(int'(TP));
      s1 = rand_str(); s2 = rand_str();
      str_l1 = s1; str_l2 = s2;
      step(5);
      pulse_update();
      add_init();
      wait_init_done(c);
      check("early_init_cycle", c, mt);
      check("early_busy_held", 32'(busy), 32'd1);
      add_refresh(s1, s2);
      wait_busy_low(c);
      check("early_end_cycle", c, mt);
      compare_pulses("early");

      check("strobe_stable", stab_err, 0);
      check("strobe_width", ep_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
